mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mips_defs.sv | 50 +++++
 rtl/alu_decoder.sv | 23 ++
 rtl/mc_control.sv | 167 ++++++++++++++++
 tb/tb_mc_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode, funct, ALU code and control state constants
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;

   function automatic logic op_known(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct field to ALU control code
module alu_decoder
   import mips_defs::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alucontrol,
   output logic       funct_ok
);

   always_comb begin
      alucontrol = ALU_ADD;
      funct_ok   = 1'b1;
      case (funct)
         FUNCT_ADD: alucontrol = ALU_ADD;
         FUNCT_SUB: alucontrol = ALU_SUB;
         FUNCT_AND: alucontrol = ALU_AND;
         FUNCT_OR:  alucontrol = ALU_OR;
         FUNCT_SLT: alucontrol = ALU_SLT;
         default:   funct_ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS control unit (Moore FSM driving datapath strobes)
module mc_control
   import mips_defs::*;
#(
   parameter int STATE_W = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [3:0] ALUControl,
   output logic       PCEn,
   output logic       InstrDone,
   output logic       IllegalOp
);

   localparam logic [STATE_W-1:0] FETCH   = STATE_W'(S_FETCH);
   localparam logic [STATE_W-1:0] DECODE  = STATE_W'(S_DECODE);
   localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(S_MEMADR);
   localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(S_MEMRD);
   localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(S_MEMWB);
   localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(S_MEMWR);
   localparam logic [STATE_W-1:0] RTYPEEX = STATE_W'(S_RTYPEEX);
   localparam logic [STATE_W-1:0] RTYPEWB = STATE_W'(S_RTYPEWB);
   localparam logic [STATE_W-1:0] BEQEX   = STATE_W'(S_BEQEX);
   localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(S_ADDIEX);
   localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(S_ADDIWB);
   localparam logic [STATE_W-1:0] JEX     = STATE_W'(S_JEX);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] next_state;
   logic               is_lw;
   logic [3:0]         funct_alu;
   logic               funct_ok;
   logic               op_legal;

   alu_decoder u_alu_decoder (
      .funct      (Funct),
      .alucontrol (funct_alu),
      .funct_ok   (funct_ok)
   );

   assign op_legal = op_known(Op) && ((Op != OP_RTYPE) || funct_ok);

   // lw/sw is captured in DECODE so later Op changes cannot redirect MEMADR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         is_lw <= 1'b0;
      end else begin
         state <= next_state;
         if (state == DECODE) begin
            is_lw <= (Op == OP_LW);
         end
      end
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            if (op_legal) begin
               case (Op)
                  OP_LW, OP_SW: next_state = MEMADR;
                  OP_RTYPE:     next_state = RTYPEEX;
                  OP_BEQ:       next_state = BEQEX;
                  OP_ADDI:      next_state = ADDIEX;
                  OP_J:         next_state = JEX;
                  default:      next_state = FETCH;
               endcase
            end
         end
         MEMADR:  next_state = is_lw ? MEMRD : MEMWR;
         MEMRD:   next_state = MEMWB;
         RTYPEEX: next_state = RTYPEWB;
         ADDIEX:  next_state = ADDIWB;
         default: next_state = FETCH;
      endcase
   end

   // Reset gates every output low, overriding FETCH's strobes
   always_comb begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      PCSrc      = PC_ALU;
      ALUControl = 4'b0000;
      PCEn       = 1'b0;
      InstrDone  = 1'b0;
      IllegalOp  = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               IRWrite    = 1'b1;
               ALUSrcB    = SRCB_FOUR;
               ALUControl = ALU_ADD;
               PCEn       = 1'b1;
            end
            DECODE: begin
               ALUSrcB    = SRCB_BRANCH;
               ALUControl = ALU_ADD;
               IllegalOp  = !op_legal;
            end
            MEMADR, ADDIEX: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = SRCB_IMM;
               ALUControl = ALU_ADD;
            end
            MEMRD: IorD = 1'b1;
            MEMWR: begin
               IorD      = 1'b1;
               MemWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            MEMWB: begin
               MemtoReg  = 1'b1;
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            ADDIWB: begin
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            RTYPEEX: begin
               ALUSrcA    = 1'b1;
               ALUControl = funct_alu;
            end
            RTYPEWB: begin
               RegDst    = 1'b1;
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            BEQEX: begin
               ALUSrcA    = 1'b1;
               ALUControl = ALU_SUB;
               PCSrc      = PC_BRANCH;
               PCEn       = Zero;
               InstrDone  = 1'b1;
            end
            JEX: begin
               PCSrc     = PC_JUMP;
               PCEn      = 1'b1;
               InstrDone = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control against an instruction-level model
module tb_mc_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [3:0] ALUControl;
   logic       PCEn, InstrDone, IllegalOp;
   logic [17:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_control #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .Zero       (Zero),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUControl (ALUControl),
      .PCEn       (PCEn),
      .InstrDone  (InstrDone),
      .IllegalOp  (IllegalOp)
   );

   assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, ALUControl, PCEn, InstrDone, IllegalOp};

   function automatic logic funct_legal(input logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   function automatic logic [3:0] funct_code(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         default:   return 4'b0010;
      endcase
   endfunction

   // Cycle count per instruction; 2 means the opcode/funct is rejected in decode
   function automatic int latency(input logic [5:0] op, input logic [5:0] f);
      case (op)
         6'b100011: return 5;
         6'b101011: return 4;
         6'b001000: return 4;
         6'b000100: return 3;
         6'b000010: return 3;
         6'b000000: return funct_legal(f) ? 4 : 2;
         default:   return 2;
      endcase
   endfunction

   function automatic logic [17:0] expv(input logic [5:0] op, input logic [5:0] f,
                                        input logic z, input int k);
      logic iord, mw, irw, rd, m2r, rw, sa, pcen, done, ill;
      logic [1:0] sb, pcs;
      logic [3:0] ac;
      int len;
      len  = latency(op, f);
      iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0;
      pcen = 0; done = 0; ill = 0; sb = 2'b00; pcs = 2'b00; ac = 4'b0000;
      if (k == 0) begin
         irw = 1; sb = 2'b01; ac = 4'b0010; pcen = 1;
      end else if (k == 1) begin
         sb = 2'b11; ac = 4'b0010; ill = (len == 2);
      end else begin
         case (op)
            6'b100011: begin
               if (k == 2) begin sa = 1; sb = 2'b10; ac = 4'b0010; end
               if (k == 3) iord = 1;
               if (k == 4) begin m2r = 1; rw = 1; end
            end
            6'b101011: begin
               if (k == 2) begin sa = 1; sb = 2'b10; ac = 4'b0010; end
               if (k == 3) begin iord = 1; mw = 1; end
            end
            6'b001000: begin
               if (k == 2) begin sa = 1; sb = 2'b10; ac = 4'b0010; end
               if (k == 3) rw = 1;
            end
            6'b000000: begin
               if (k == 2) begin sa = 1; ac = funct_code(f); end
               if (k == 3) begin rd = 1; rw = 1; end
            end
            6'b000100: begin sa = 1; ac = 4'b0110; pcs = 2'b01; pcen = z; end
            6'b000010: begin pcs = 2'b10; pcen = 1; end
            default: ;
         endcase
      end
      done = (len != 2) && (k == len - 1);
      return {iord, mw, irw, rd, m2r, rw, sa, sb, pcs, ac, pcen, done, ill};
   endfunction

   task automatic check(input string tag, input logic [17:0] exp, input int k);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%05h expected=%05h", tag, k, obs, exp);
      end
   endtask

   // Starts just after a rising edge with the FSM in FETCH; Op/Funct are randomised
   // in every cycle where the controller is supposed to ignore them.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] f,
                            input int ncyc, input int zsel);
      int len;
      len = latency(op, f);
      if (ncyc >= 0 && ncyc < len) len = ncyc;
      for (int k = 0; k < len; k++) begin
         if (k == 1 || (op == 6'b000000 && k == 2)) begin
            Op = op; Funct = f;
         end else begin
            Op = 6'($urandom); Funct = 6'($urandom);
         end
         Zero = (zsel == 2) ? 1'($urandom) : (zsel == 1);
         @(negedge clk);
         check(tag, expv(op, f, Zero, k), k);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] rop, rf;
      logic [5:0] fl [5];
      fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
      fl[3] = 6'b100101; fl[4] = 6'b101010;

      reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hold", 18'd0, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      run_instr("lw",        6'b100011, 6'b000000, -1, 2);
      run_instr("rtype_slt", 6'b000000, 6'b101010, -1, 2);
      run_instr("beq_taken", 6'b000100, 6'b000000, -1, 1);
      run_instr("beq_not",   6'b000100, 6'b000000, -1, 0);
      run_instr("illegal_op",6'b111111, 6'b000000, -1, 2);
      run_instr("illegal_fn",6'b000000, 6'b000111, -1, 2);
      run_instr("j",         6'b000010, 6'b000000, -1, 2);
      run_instr("addi",      6'b001000, 6'b000000, -1, 2);
      run_instr("sw",        6'b101011, 6'b000000, -1, 2);

      run_instr("sw_pre",    6'b101011, 6'b000000, 3, 2);
      #1 check("memwr_before_reset", expv(6'b101011, 6'b0, Zero, 3), 3);
      reset = 1'b1;
      #1 check("reset_async", 18'd0, 0);
      @(negedge clk);
      check("reset_mid_hold", 18'd0, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      run_instr("post_reset_lw", 6'b100011, 6'b000000, -1, 2);

      for (int i = 0; i < 300; i++) begin
         rf = fl[$urandom_range(0, 4)];
         case ($urandom_range(0, 7))
            0: rop = 6'b100011;
            1: rop = 6'b101011;
            2: rop = 6'b000000;
            3: rop = 6'b000100;
            4: rop = 6'b001000;
            5: rop = 6'b000010;
            6: rop = 6'($urandom);
            default: begin rop = 6'b000000; rf = 6'($urandom); end
         endcase
         run_instr("random", rop, rf, -1, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
